llc_fwd_gen: RTL
================

// Module: llc_fwd_gen
// PURPOSE
//  Downstream of the LLC lookup stage. Takes the owned-word mask and per-word owner cache IDs of a hit or evict line.
//  Emits one forward/recall message per distinct owner; each message carries the mask of all words that owner holds.
//  Words owned by the requester itself are optionally excluded and reported back.
//  Feeds the LLC forward-request output queue.
// PARAMETERS
//  WORDS        4   words per line (WORDS_PER_LINE)
//  CID_W        4   cache ID width (CACHE_ID_WIDTH)
//  LINE_ADDR_W  26  line address width
// PORTS
//  clk            in   1              clock
//  rst            in   1              reset, asynchronous, active-high
//  start_valid    in   1              recall request valid
//  start_ready    out  1              block idle, request accepted when valid&ready
//  start_mask     in   WORDS          owned-word mask (bit i = word i owned)
//  start_owner    in   WORDS*CID_W    owner ID of word i at [i*CID_W +: CID_W]
//  start_addr     in   LINE_ADDR_W    line address
//  start_skip_en  in   1              exclude words owned by start_skip_id
//  start_skip_id  in   CID_W          requester cache ID
//  fwd_valid      out  1              forward message valid
//  fwd_ready      in   1              downstream accepts message
//  fwd_dest       out  CID_W          destination owner ID
//  fwd_mask       out  WORDS          words covered by this message
//  fwd_addr       out  LINE_ADDR_W    line address
//  busy           out  1              state != IDLE
//  done           out  1              one-cycle pulse, all messages sent
//  self_mask      out  WORDS          words skipped as requester-owned, valid with done
// BEHAVIOUR
//  Reset: state=IDLE.
//   - All registered outputs 0: fwd_valid, fwd_dest, fwd_mask, fwd_addr, done, self_mask, pending, skip regs.
//   - start_ready=1, busy=0.
//  start_ready = (state==IDLE), combinational.
//  FSM states: IDLE, SCAN, SEND, DONE.
//  IDLE: on start_valid, latch inputs; pending<=start_mask; self_mask<=0; go SCAN.
//  SCAN: if pending==0, go DONE. Otherwise:
//   - w = lowest set bit of pending; d = owner[w].
//   - grp = all pending bits j with owner[j]==d.
//   - If skip_en && d==skip_id: self_mask|=grp, pending&=~grp, stay SCAN (one group per cycle).
//   - Else register fwd_dest=d, fwd_mask=grp, fwd_addr=addr, fwd_valid<=1, go SEND.
//  SEND: fwd_valid, fwd_dest, fwd_mask, fwd_addr held stable until fwd_ready.
//   - On valid&ready: fwd_valid<=0, pending&=~fwd_mask.
//   - Go DONE if the new pending==0, else SCAN.
//  DONE: done=1 for exactly one cycle, self_mask valid; go IDLE.
//  Latency: accept at edge k; SCAN in cycle k+1; first fwd_valid in cycle k+2.
//   - Each later message comes 2 cycles after the previous handshake.
//   - done asserts the cycle after the last handshake.
//  Message order: ascending lowest word index of each group.
//  No bubble-free back-to-back messages are required.
//  Boundaries:
//   - start_mask==0: no messages; done in cycle k+2.
//   - All words skipped: no messages; done after the skip cycles.
//   - fwd_ready held high before SEND: handshake occurs in the first SEND cycle.
//   - start_valid while busy: ignored; it is not latched and not lost state.
//   - Owner IDs of unmasked words are don't-care and never compared.
//   - rst mid-operation: immediate return to reset values.
//     fwd_valid drops asynchronously; no done; the partial transaction is discarded.
// TESTING
//  1. mask=1111, owners w0..w3={3,3,5,3}, skip_en=0.
//     -> fwd (3,1011) then (5,0100); done; self_mask=0000.
//  2. Same stimulus with skip_en=1, skip_id=3.
//     -> single fwd (5,0100); done; self_mask=1011.
//  3. mask=0000.
//     -> no fwd_valid; done pulses 2 cycles after accept; start_ready high next cycle.
//  4. mask=1111, owners {1,2,3,4}, fwd_ready low 5 cycles per message.
//     -> 4 messages masks 0001,0010,0100,1000 in order; fields stable while stalled.
//  5. rst pulsed during SEND of test 1.
//     -> fwd_valid=0 immediately, no done; a fresh request after release runs as test 1.
//  6. start_valid=1 held while busy with a different payload.
//     -> second payload ignored until start_ready; accepted only in IDLE.

Source files
------------

// File: rtl/llc_fwd_gen.sv
// llc_fwd_gen: turns an owned-word mask plus per-word owner IDs into one
// forward/recall message per distinct owner. Each message carries the mask
// of all words that owner holds. Requester-owned words can be excluded and
// are reported back in self_mask alongside the done pulse.
module llc_fwd_gen #(
  parameter int unsigned WORDS       = 4,
  parameter int unsigned CID_W       = 4,
  parameter int unsigned LINE_ADDR_W = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [WORDS-1:0]         start_mask,
  input  logic [WORDS*CID_W-1:0]   start_owner,
  input  logic [LINE_ADDR_W-1:0]   start_addr,
  input  logic                     start_skip_en,
  input  logic [CID_W-1:0]         start_skip_id,
  output logic                     fwd_valid,
  input  logic                     fwd_ready,
  output logic [CID_W-1:0]         fwd_dest,
  output logic [WORDS-1:0]         fwd_mask,
  output logic [LINE_ADDR_W-1:0]   fwd_addr,
  output logic                     busy,
  output logic                     done,
  output logic [WORDS-1:0]         self_mask
);

  localparam int unsigned OWN_W = WORDS * CID_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]             state_q,     state_d;
  logic [WORDS-1:0]       pending_q,   pending_d;
  logic [OWN_W-1:0]       owner_q,     owner_d;
  logic [LINE_ADDR_W-1:0] addr_q,      addr_d;
  logic                   skip_en_q,   skip_en_d;
  logic [CID_W-1:0]       skip_id_q,   skip_id_d;
  logic                   fwd_valid_q, fwd_valid_d;
  logic [CID_W-1:0]       fwd_dest_q,  fwd_dest_d;
  logic [WORDS-1:0]       fwd_mask_q,  fwd_mask_d;
  logic [LINE_ADDR_W-1:0] fwd_addr_q,  fwd_addr_d;
  logic                   done_q,      done_d;
  logic [WORDS-1:0]       self_mask_q, self_mask_d;

  // Owner of the lowest pending word and every pending word sharing it
  logic [CID_W-1:0]       lead_id;
  logic                   lead_found;
  logic [WORDS-1:0]       grp;
  logic [WORDS-1:0]       pending_after_send;

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

  assign fwd_valid   = fwd_valid_q;
  assign fwd_dest    = fwd_dest_q;
  assign fwd_mask    = fwd_mask_q;
  assign fwd_addr    = fwd_addr_q;
  assign done        = done_q;
  assign self_mask   = self_mask_q;

  assign pending_after_send = pending_q & ~fwd_mask_q;

  // Find the leading owner among pending words; unmasked words never take part
  always_comb begin
    lead_found = 1'b0;
    lead_id    = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (pending_q[i] && !lead_found) begin
        lead_found = 1'b1;
        lead_id    = owner_q[i*CID_W +: CID_W];
      end
    end
  end

  // Gather all pending words held by the leading owner
  always_comb begin
    grp = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      grp[i] = pending_q[i] && (owner_q[i*CID_W +: CID_W] == lead_id);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    skip_en_d   = skip_en_q;
    skip_id_d   = skip_id_q;
    fwd_valid_d = fwd_valid_q;
    fwd_dest_d  = fwd_dest_q;
    fwd_mask_d  = fwd_mask_q;
    fwd_addr_d  = fwd_addr_q;
    done_d      = 1'b0;
    self_mask_d = self_mask_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          owner_d     = start_owner;
          addr_d      = start_addr;
          skip_en_d   = start_skip_en;
          skip_id_d   = start_skip_id;
          pending_d   = start_mask;
          self_mask_d = '0;
          state_d     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (pending_q == '0) begin
          // done is registered on entry so it is high exactly while in DONE
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (skip_en_q && (lead_id == skip_id_q)) begin
          self_mask_d = self_mask_q | grp;
          pending_d   = pending_q & ~grp;
        end else begin
          fwd_dest_d  = lead_id;
          fwd_mask_d  = grp;
          fwd_addr_d  = addr_q;
          fwd_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (fwd_ready) begin
          fwd_valid_d = 1'b0;
          pending_d   = pending_after_send;
          if (pending_after_send == '0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      skip_en_q   <= 1'b0;
      skip_id_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_dest_q  <= '0;
      fwd_mask_q  <= '0;
      fwd_addr_q  <= '0;
      done_q      <= 1'b0;
      self_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      skip_en_q   <= skip_en_d;
      skip_id_q   <= skip_id_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_dest_q  <= fwd_dest_d;
      fwd_mask_q  <= fwd_mask_d;
      fwd_addr_q  <= fwd_addr_d;
      done_q      <= done_d;
      self_mask_q <= self_mask_d;
    end
  end

endmodule
